// File: rtl/serial_odev_pkg.sv
// Shared types and defaults for the serial output device.
// Imported by the FIFO and the transmitter top.
package serial_odev_pkg;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_FIFO_DEPTH   = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  function automatic logic [7:0] term_cnt(
    input int clks
  );
    return 8'(clks - 1);
  endfunction

endpackage

// File: rtl/serial_odev_fifo.sv
// Synchronous byte FIFO with push, pop, full and level.
// A push while full is ignored; head data is always visible on dout.
module serial_odev_fifo
  import serial_odev_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_bar,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic [4:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == 5'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (level != 5'd0);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= 5'd0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: level and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/serial_odev.sv
// Buffered serial output device: CPU writes bytes into a FIFO,
// an 8N1 transmitter drains them onto txd, LSB first.
module serial_odev
  import serial_odev_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_bar,
  input  logic       wr_bar,
  input  logic [7:0] d_in,
  output logic       txd,
  output logic       busy,
  output logic       full,
  output logic [4:0] level,
  output logic       ovf
);

  localparam logic [7:0] TC = term_cnt(CLKS_PER_BIT);

  state_t     state;
  state_t     state_d;
  logic [7:0] cnt;
  logic [7:0] cnt_d;
  logic [2:0] bit_idx;
  logic [2:0] bit_d;
  logic [7:0] shreg;
  logic [7:0] sh_d;
  logic       txd_d;
  logic       pop;
  logic       wr;
  logic [7:0] head;

  assign wr   = !wr_bar;
  assign busy = (state != IDLE) || (level != 5'd0);

  serial_odev_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_bar (rst_bar),
    .push    (wr),
    .pop     (pop),
    .din     (d_in),
    .dout    (head),
    .full    (full),
    .level   (level)
  );

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      ovf <= 1'b0;
    end else if (wr && full) begin
      ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      txd     <= 1'b1;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      shreg   <= sh_d;
      txd     <= txd_d;
    end
  end

  // txd_d is the line level for the cycle after the edge,
  // so the output stays a plain flop.
  always_comb begin
    state_d = state;
    cnt_d   = (cnt == TC) ? 8'd0 : cnt + 8'd1;
    bit_d   = bit_idx;
    sh_d    = shreg;
    txd_d   = txd;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        txd_d = 1'b1;
        cnt_d = 8'd0;
        if (level != 5'd0) begin
          pop     = 1'b1;
          sh_d    = head;
          bit_d   = 3'd0;
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (cnt == TC) begin
          state_d = DATA;
          txd_d   = shreg[0];
        end
      end
      DATA: begin
        if (cnt == TC) begin
          if (bit_idx == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_idx + 3'd1;
            sh_d  = {1'b0, shreg[7:1]};
            txd_d = shreg[1];
          end
        end
      end
      STOP: begin
        if (cnt == TC) begin
          state_d = IDLE;
          txd_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_odev.sv
// Directed bench for serial_odev: framing, FIFO limits,
// overflow, back-to-back gap, async reset, fast baud.
module tb_serial_odev;

  logic       clk;
  logic       rst_bar;
  logic       wr_bar;
  logic [7:0] d_in;
  logic       txd;
  logic       busy;
  logic       full;
  logic [4:0] level;
  logic       ovf;

  logic       wr_bar2;
  logic [7:0] d_in2;
  logic       txd2;
  logic       busy2;
  logic       full2;
  logic [4:0] level2;
  logic       ovf2;

  int errors;
  int checks;

  serial_odev #(
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4)
  ) u4 (
    .clk     (clk),
    .rst_bar (rst_bar),
    .wr_bar  (wr_bar),
    .d_in    (d_in),
    .txd     (txd),
    .busy    (busy),
    .full    (full),
    .level   (level),
    .ovf     (ovf)
  );

  serial_odev #(
    .CLKS_PER_BIT (2),
    .FIFO_DEPTH   (4)
  ) u2 (
    .clk     (clk),
    .rst_bar (rst_bar),
    .wr_bar  (wr_bar2),
    .d_in    (d_in2),
    .txd     (txd2),
    .busy    (busy2),
    .full    (full2),
    .level   (level2),
    .ovf     (ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic frame_bit(
    input logic [7:0] b,
    input int         i,
    input int         c
  );
    if (i < c) return 1'b0;
    if (i < 9 * c) return b[(i - c) / c];
    return 1'b1;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_bar = 1'b0;
    wr_bar  = 1'b1;
    wr_bar2 = 1'b1;
    tick();
    tick();
    rst_bar = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks += 5;
    if (txd !== 1'b1) begin
      errors++; $display("FAIL reset_txd got %b want 1", txd);
    end
    if (level !== 5'd0) begin
      errors++; $display("FAIL reset_level got %0d want 0", level);
    end
    if (full !== 1'b0) begin
      errors++; $display("FAIL reset_full got %b want 0", full);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b want 0", busy);
    end
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL reset_ovf got %b want 0", ovf);
    end
    rst_bar = 1'b1;
  endtask

  task automatic test_frame;
    wr_bar = 1'b0;
    d_in   = 8'hA5;
    tick();
    wr_bar = 1'b0;
    wr_bar = 1'b1;
    checks += 3;
    if (level !== 5'd1) begin
      errors++; $display("FAIL first_write_level got %0d want 1", level);
    end
    if (busy !== 1'b1) begin
      errors++; $display("FAIL first_write_busy got %b want 1", busy);
    end
    if (txd !== 1'b1) begin
      errors++; $display("FAIL first_write_txd got %b want 1", txd);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (txd !== frame_bit(8'hA5, i, 4)) begin
        errors++;
        $display("FAIL frame_a5[%0d] got %b want %b",
                 i, txd, frame_bit(8'hA5, i, 4));
      end
      if (i == 0) begin
        checks++;
        if (level !== 5'd0) begin
          errors++; $display("FAIL pop_level got %0d want 0", level);
        end
      end
      if (i == 39) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL stop_busy got %b want 1", busy);
        end
      end
    end
    tick();
    checks += 2;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL done_busy got %b want 0", busy);
    end
    if (txd !== 1'b1) begin
      errors++; $display("FAIL done_txd got %b want 1", txd);
    end
  endtask

  task automatic test_overflow;
    do_reset();
    wr_bar = 1'b0;
    d_in   = 8'h10;
    tick();
    d_in = 8'h11;
    tick();
    checks += 2;
    if (txd !== 1'b0) begin
      errors++; $display("FAIL ovf_pop_txd got %b want 0", txd);
    end
    if (level !== 5'd1) begin
      errors++; $display("FAIL ovf_pushpop_level got %0d want 1", level);
    end
    d_in = 8'h12;
    tick();
    d_in = 8'h13;
    tick();
    d_in = 8'h14;
    tick();
    checks += 3;
    if (level !== 5'd4) begin
      errors++; $display("FAIL fill_level got %0d want 4", level);
    end
    if (full !== 1'b1) begin
      errors++; $display("FAIL fill_full got %b want 1", full);
    end
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL fill_ovf got %b want 0", ovf);
    end
    d_in = 8'h15;
    tick();
    wr_bar = 1'b1;
    checks += 2;
    if (ovf !== 1'b1) begin
      errors++; $display("FAIL drop_ovf got %b want 1", ovf);
    end
    if (level !== 5'd4) begin
      errors++; $display("FAIL drop_level got %0d want 4", level);
    end
    tick();
    checks++;
    if (ovf !== 1'b1) begin
      errors++; $display("FAIL sticky_ovf got %b want 1", ovf);
    end
  endtask

  task automatic test_full_pop;
    do_reset();
    wr_bar = 1'b0;
    d_in   = 8'h21;
    tick();
    wr_bar = 1'b1;
    tick();
    wr_bar = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d_in = 8'h22 + 8'(i);
      tick();
    end
    wr_bar = 1'b1;
    repeat (36) tick();
    checks += 3;
    if (full !== 1'b1) begin
      errors++; $display("FAIL pre_pop_full got %b want 1", full);
    end
    if (txd !== 1'b1) begin
      errors++; $display("FAIL pre_pop_txd got %b want 1", txd);
    end
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL pre_pop_ovf got %b want 0", ovf);
    end
    wr_bar = 1'b0;
    d_in   = 8'h26;
    tick();
    wr_bar = 1'b1;
    checks += 3;
    if (ovf !== 1'b1) begin
      errors++; $display("FAIL full_pop_ovf got %b want 1", ovf);
    end
    if (level !== 5'd3) begin
      errors++; $display("FAIL full_pop_level got %0d want 3", level);
    end
    if (txd !== 1'b0) begin
      errors++; $display("FAIL full_pop_txd got %b want 0", txd);
    end
  endtask

  task automatic test_back_to_back;
    logic cap [81];
    logic want;
    int   gap;
    do_reset();
    wr_bar = 1'b0;
    d_in   = 8'h00;
    tick();
    d_in = 8'hFF;
    tick();
    wr_bar = 1'b1;
    cap[0] = txd;
    for (int i = 1; i < 81; i++) begin
      tick();
      cap[i] = txd;
    end
    for (int i = 0; i < 81; i++) begin
      if (i < 40) want = frame_bit(8'h00, i, 4);
      else if (i == 40) want = 1'b1;
      else want = frame_bit(8'hFF, i - 41, 4);
      checks++;
      if (cap[i] !== want) begin
        errors++;
        $display("FAIL b2b_wave[%0d] got %b want %b", i, cap[i], want);
      end
    end
    gap = 0;
    for (int k = 36; k < 81; k++) begin
      if (cap[k] !== 1'b1) break;
      gap++;
    end
    checks++;
    if (gap != 5) begin
      errors++; $display("FAIL b2b_gap got %0d want 5", gap);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL b2b_busy got %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    wr_bar = 1'b0;
    d_in   = 8'h3C;
    tick();
    d_in = 8'h5A;
    tick();
    d_in = 8'h77;
    tick();
    wr_bar = 1'b1;
    checks++;
    if (level !== 5'd2) begin
      errors++; $display("FAIL mid_level got %0d want 2", level);
    end
    repeat (4) tick();
    checks++;
    if (txd !== 1'b0) begin
      errors++; $display("FAIL mid_data_txd got %b want 0", txd);
    end
    rst_bar = 1'b0;
    #1;
    checks += 4;
    if (txd !== 1'b1) begin
      errors++; $display("FAIL async_txd got %b want 1", txd);
    end
    if (level !== 5'd0) begin
      errors++; $display("FAIL async_level got %0d want 0", level);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL async_busy got %b want 0", busy);
    end
    if (full !== 1'b0) begin
      errors++; $display("FAIL async_full got %b want 0", full);
    end
    tick();
    rst_bar = 1'b1;
    wr_bar  = 1'b0;
    d_in    = 8'h96;
    tick();
    wr_bar = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (txd !== frame_bit(8'h96, i, 4)) begin
        errors++;
        $display("FAIL post_rst[%0d] got %b want %b",
                 i, txd, frame_bit(8'h96, i, 4));
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL post_rst_busy got %b want 0", busy);
    end
  endtask

  task automatic test_fast_baud;
    bit seen;
    int len;
    wr_bar2 = 1'b0;
    d_in2   = 8'h01;
    tick();
    wr_bar2 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (txd2 === 1'b0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL c2_start got none want txd low");
    end
    len = 0;
    while (seen && busy2 === 1'b1 && len < 40) begin
      checks++;
      if (txd2 !== frame_bit(8'h01, len, 2)) begin
        errors++;
        $display("FAIL c2_wave[%0d] got %b want %b",
                 len, txd2, frame_bit(8'h01, len, 2));
      end
      len++;
      tick();
    end
    checks += 4;
    if (len != 20) begin
      errors++; $display("FAIL c2_len got %0d want 20", len);
    end
    if (txd2 !== 1'b1) begin
      errors++; $display("FAIL c2_idle_txd got %b want 1", txd2);
    end
    if (level2 !== 5'd0 || full2 !== 1'b0) begin
      errors++;
      $display("FAIL c2_fifo got level=%0d full=%b want 0/0",
               level2, full2);
    end
    if (ovf2 !== 1'b0) begin
      errors++; $display("FAIL c2_ovf got %b want 0", ovf2);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst_bar = 1'b0;
    wr_bar  = 1'b1;
    wr_bar2 = 1'b1;
    d_in    = 8'h00;
    d_in2   = 8'h00;
    test_reset();
    test_frame();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_reset_mid();
    test_fast_baud();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_odev.md
SERIAL_ODEV -- requirements
Module: serial_odev

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, legal range 2..255.
REQ-002 Parameter FIFO_DEPTH, default 4: byte slots in the transmit FIFO, power of two, legal range 2..16.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_bar  input  1  reset, asynchronous, active-low.
REQ-005 wr_bar  input  1  active-low write strobe, driven by the CPU output-device decoder select line.
REQ-006 d_in  input  8  write data from the CPU databus, sampled on the rising clk edge while wr_bar=0.
REQ-007 txd  output  1  serial line output; idles high.
REQ-008 busy  output  1  high while a frame is in progress or the FIFO is non-empty.
REQ-009 full  output  1  high when the FIFO holds FIFO_DEPTH bytes.
REQ-010 level  output  5  current FIFO occupancy, 0..FIFO_DEPTH.
REQ-011 ovf  output  1  sticky overflow flag; set when a write is dropped.

Function
REQ-012 Write accept: on a rising edge with wr_bar=0 and full=0, d_in is pushed to the FIFO tail.
REQ-013 A write with full=0 and a pop on the same edge are both performed; level is unchanged.
REQ-014 A write on an edge where full=1 (the value before the edge) is dropped, FIFO contents are unchanged, and ovf is set on that edge, even if a pop occurs on the same edge.
REQ-015 A write held low for k consecutive edges produces k pushes, each subject to REQ-012..014.
REQ-016 State machine states: IDLE, START, DATA, STOP.
REQ-017 IDLE: txd=1; if level>0, pop the head into the shift register, clear the bit counter and the baud counter, and go to START.
REQ-018 START: txd=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-019 DATA: shift the 8 bits out LSB first, each held for CLKS_PER_BIT cycles, then go to STOP.
REQ-020 STOP: txd=1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-021 Latency: for a write accepted at edge N into an empty FIFO with the FSM in IDLE, the pop occurs at edge N+1 and txd falls after edge N+1.
REQ-022 Back-to-back frames: when STOP completes with level>0, exactly one IDLE cycle precedes the next START, so the inter-frame gap is CLKS_PER_BIT+1 high cycles.
REQ-023 Baud counter: runs 0..CLKS_PER_BIT-1 and wraps to 0; the state or bit advances on terminal count only.
REQ-024 FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.
REQ-025 level = number of pushes minus number of pops, and never exceeds FIFO_DEPTH.
REQ-026 full = (level==FIFO_DEPTH).
REQ-027 busy = (state!=IDLE) or (level!=0).
REQ-028 ovf clears only on reset.
REQ-029 txd is a registered output with no combinational path from any input.

Reset
REQ-030 While rst_bar=0, independent of clk: state=IDLE, txd=1, level=0, full=0, busy=0, ovf=0, and all pointers and counters are 0.
REQ-031 Reset asserted mid-frame aborts the frame: txd goes to 1 immediately and FIFO contents are discarded.
REQ-032 Writes on the first edge after rst_bar deasserts are accepted.

Structure
REQ-033 Package serial_odev_pkg holds the FSM state enum and the default CLKS_PER_BIT and FIFO_DEPTH constants.
REQ-034 Sub-module serial_odev_fifo (synchronous FIFO with push, pop, full, level) is instantiated once.
REQ-035 The FSM, baud counter, bit counter and shift register reside in serial_odev.

Verification
REQ-036 CLKS_PER_BIT=4, write 0xA5 once -> after edge N+1: txd=0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 each held 4 cycles, then 1 for 4 cycles; busy falls after the stop bit.
REQ-037 Write 5 bytes on consecutive edges with FIFO_DEPTH=4 -> first 4 accepted (first popped at edge N+1), 5th accepted since level=3 on that edge, ovf stays 0; then a 6th write -> dropped, ovf=1.
REQ-038 Fill FIFO, then write on the same edge the FSM pops -> write dropped, ovf=1, level=FIFO_DEPTH-1 after the edge.
REQ-039 Two queued bytes 0x00, 0xFF -> inter-frame high gap exactly CLKS_PER_BIT+1 cycles; waveform matches the frame format.
REQ-040 Assert rst_bar=0 mid-DATA with level=2 -> txd=1 asynchronously, level=0, busy=0; a write after release transmits normally.
REQ-041 CLKS_PER_BIT=2, write 0x01 -> frame length exactly 20 cycles from start-bit fall to stop-bit end.
